cache_mem_responder: RTL

- Memory-side responder for the cache miss/uncached interface. It accepts line and word read requests and returns data as 32-bit beats on `ret_valid`/`ret_last`/`ret_data`.
- It accepts 128-bit line write-backs and strobed word writes.
- It is backed by an internal word-addressed array.
- It is the simulation and bring-up target that stands in for the bus bridge behind the instruction and data caches.

---
 rtl/cache_mem_responder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_mem_responder.sv
// Memory-side responder behind the I/D caches: word/line reads returned
// as 32-bit beats after RD_LAT cycles, line write-backs and strobed word writes.
//
// Ports:
//   clk, resetn                          clock, async active-low reset
//   rd_req/rd_type/rd_addr -> rd_rdy     read request channel
//   ret_valid/ret_last/ret_data          registered return beats, no backpressure
//   wr_req/wr_type/wr_addr/wr_wstrb/
//   wr_data -> wr_rdy                    write request channel (line = type 100)
module cache_mem_responder #(
    parameter int MEM_AW = 12,
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_LINE
    } state_t;

    localparam int         DEPTH     = 1 << MEM_AW;
    localparam logic [3:0] LP_LAT_M1 = 4'(RD_LAT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_mem [DEPTH];
    logic [MEM_AW-1:0]   r_rd_idx;
    logic [MEM_AW-1:0]   r_wr_base;
    logic                r_rd_line;
    logic [127:0]        r_line;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [1:0]          r_beat;
    logic [1:0]          w_beat_nxt;
    logic [1:0]          r_wk;
    logic [1:0]          w_wk_nxt;
    logic                r_ret_valid;
    logic                r_ret_last;
    logic [31:0]         r_ret_data;
    logic                w_ret_valid_nxt;
    logic                w_ret_last_nxt;
    logic [31:0]         w_ret_data_nxt;

    logic                w_idle;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_wr_line;
    logic                w_rd_line;
    logic [MEM_AW-1:0]   w_wr_idx;
    logic [MEM_AW-1:0]   w_rd_req_idx;
    logic [MEM_AW-1:0]   w_rd_idx;
    logic [31:0]         w_rword;
    logic                w_we;
    logic [MEM_AW-1:0]   w_widx;
    logic [31:0]         w_wdata;
    logic [3:0]          w_wmask;
    logic                w_unused;

    // Write has priority over a same-cycle read so a victim write-back
    // always lands before its refill is served.
    assign w_idle       = (r_state == IDLE);
    assign wr_rdy       = w_idle & resetn;
    assign rd_rdy       = w_idle & resetn & ~wr_req;
    assign w_wr_acc     = wr_req & wr_rdy;
    assign w_rd_acc     = rd_req & rd_rdy;
    assign w_wr_line    = (wr_type == 3'b100);
    assign w_rd_line    = (rd_type == 3'b100);
    assign w_wr_idx     = wr_addr[MEM_AW+1:2];
    assign w_rd_req_idx = rd_addr[MEM_AW+1:2];

    // Line base has zero low bits, so OR-ing the beat number walks the line.
    assign w_rd_idx = {r_rd_idx[MEM_AW-1:2], r_rd_idx[1:0] | r_beat};
    assign w_rword  = r_mem[w_rd_idx];

    assign ret_valid = r_ret_valid;
    assign ret_last  = r_ret_last;
    assign ret_data  = r_ret_data;

    assign w_unused = ^{rd_addr[31:MEM_AW+2], rd_addr[1:0],
                        wr_addr[31:MEM_AW+2], wr_addr[1:0]};

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_beat_nxt      = r_beat;
        w_wk_nxt        = r_wk;
        w_ret_valid_nxt = 1'b0;
        w_ret_last_nxt  = 1'b0;
        w_ret_data_nxt  = r_ret_data;
        w_we            = 1'b0;
        w_widx          = w_wr_idx;
        w_wdata         = wr_data[31:0];
        w_wmask         = wr_wstrb;
        case (r_state)
            IDLE: begin
                if (w_wr_acc) begin
                    if (w_wr_line) begin
                        w_state_nxt = WR_LINE;
                        w_wk_nxt    = 2'd0;
                    end else begin
                        w_we = 1'b1;
                    end
                end else if (w_rd_acc) begin
                    w_state_nxt = RD_WAIT;
                    w_cnt_nxt   = LP_LAT_M1;
                    w_beat_nxt  = 2'd0;
                end
            end
            RD_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt     = RD_BURST;
                    w_ret_valid_nxt = 1'b1;
                    w_ret_last_nxt  = ~r_rd_line;
                    w_ret_data_nxt  = w_rword;
                    w_beat_nxt      = 2'd1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RD_BURST: begin
                if (r_ret_last) begin
                    w_state_nxt = IDLE;
                    w_beat_nxt  = 2'd0;
                end else begin
                    w_ret_valid_nxt = 1'b1;
                    w_ret_last_nxt  = (r_beat == 2'd3);
                    w_ret_data_nxt  = w_rword;
                    w_beat_nxt      = r_beat + 2'd1;
                end
            end
            WR_LINE: begin
                w_we     = 1'b1;
                w_widx   = {r_wr_base[MEM_AW-1:2], r_wk};
                w_wdata  = r_line[{r_wk, 5'd0} +: 32];
                w_wmask  = 4'hF;
                w_wk_nxt = r_wk + 2'd1;
                if (r_wk == 2'd3) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_beat      <= 2'd0;
            r_wk        <= 2'd0;
            r_ret_valid <= 1'b0;
            r_ret_last  <= 1'b0;
            r_ret_data  <= 32'd0;
            r_rd_line   <= 1'b0;
            r_rd_idx    <= '0;
            r_wr_base   <= '0;
            r_line      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_beat      <= w_beat_nxt;
            r_wk        <= w_wk_nxt;
            r_ret_valid <= w_ret_valid_nxt;
            r_ret_last  <= w_ret_last_nxt;
            r_ret_data  <= w_ret_data_nxt;
            if (w_wr_acc && w_wr_line) begin
                r_line    <= wr_data;
                r_wr_base <= {w_wr_idx[MEM_AW-1:2], 2'b00};
            end
            if (w_rd_acc) begin
                r_rd_line <= w_rd_line;
                r_rd_idx  <= w_rd_line ? {w_rd_req_idx[MEM_AW-1:2], 2'b00}
                                       : w_rd_req_idx;
            end
        end
    end

    // Backing array is never cleared; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_we && w_wmask[b]) begin
                r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

endmodule
